bus_initiator: RTL

Bus initiator for the 4-bit multiplexed CPU bus: runs the eight-phase instruction cycle, drives `sync` and the ROM/RAM command lines, and transfers 12-bit addresses and 8-bit opcode bytes to and from the ROM/RAM responders. The CPU core is a full instruction-executing master. This block is a host-driven master that runs single bus transactions in its place. Test systems and bring-up harnesses use it to exercise responder chips, with a valid/ready request port and a pulsed response port on the host side. It connects to the shared bus exactly where the CPU's `data_o`/`data_en`/`sync`/`rom_cmd`/`ram_cmd_n` connect.

---
 rtl/bus_initiator.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bus_initiator.sv
// Host-driven master for the 4-bit multiplexed CPU bus. It runs the eight-phase
// instruction cycle and issues one queued fetch (plus an optional SRC send) per cycle.
module bus_initiator (
    input  logic        clock,
    input  logic        reset,
    input  logic        halt,
    input  logic [3:0]  data_i,
    output logic [3:0]  data_o,
    output logic        data_en,
    output logic        sync,
    output logic        rom_cmd,
    output logic [3:0]  ram_cmd_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_addr,
    input  logic        req_src,
    input  logic [7:0]  req_src_data,
    input  logic [1:0]  req_bank,
    output logic        resp_valid,
    output logic [7:0]  resp_data
);

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    typedef struct packed {
        logic [11:0] addr;
        logic        src;
        logic [7:0]  src_data;
        logic [1:0]  bank;
    } req_t;

    logic [2:0] phase;
    logic       pend_v;
    logic       act_v;
    req_t       pend;
    req_t       act;
    req_t       req_in;
    logic [3:0] opr;
    logic [3:0] opa;
    logic       accept;
    logic       advance;
    logic       cycle_end;
    logic [3:0] bank_sel_n;

    assign req_in    = '{addr: req_addr, src: req_src, src_data: req_src_data, bank: req_bank};
    assign req_ready = !pend_v && !reset;
    assign accept    = req_valid && req_ready;
    assign advance   = !halt;
    assign cycle_end = advance && (phase == PH_X3);
    assign sync      = (phase == PH_X3) && !reset;

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            phase      <= PH_X3;
            pend_v     <= 1'b0;
            act_v      <= 1'b0;
            pend       <= '0;
            act        <= '0;
            opr        <= 4'h0;
            opa        <= 4'h0;
            resp_valid <= 1'b0;
            resp_data  <= 8'h00;
        end else begin
            // The completion pulse is a single clock even if halt holds A1.
            resp_valid <= 1'b0;
            if (advance) begin
                phase <= phase + 3'd1;
            end
            if (advance && phase == PH_M1) begin
                opr <= data_i;
            end
            if (advance && phase == PH_M2) begin
                opa <= data_i;
            end
            if (cycle_end) begin
                if (act_v) begin
                    resp_valid <= 1'b1;
                    resp_data  <= {opr, opa};
                end
                // An empty slot at X3 lets a same-clock request start in the next A1.
                if (pend_v) begin
                    act    <= pend;
                    act_v  <= 1'b1;
                    pend_v <= 1'b0;
                end else if (accept) begin
                    act   <= req_in;
                    act_v <= 1'b1;
                end else begin
                    act_v <= 1'b0;
                end
            end else if (accept) begin
                pend   <= req_in;
                pend_v <= 1'b1;
            end
        end
    end

    assign bank_sel_n = ~(4'b0001 << act.bank);

    always_comb begin
        // NOTE: defaults first so no phase leaves an output unassigned (no latch).
        data_o    = 4'h0;
        data_en   = 1'b0;
        rom_cmd   = 1'b0;
        ram_cmd_n = 4'hF;
        if (act_v) begin
            case (phase)
                PH_A1: begin
                    data_en = 1'b1;
                    data_o  = act.addr[3:0];
                end
                PH_A2: begin
                    data_en = 1'b1;
                    data_o  = act.addr[7:4];
                end
                PH_A3: begin
                    data_en   = 1'b1;
                    data_o    = act.addr[11:8];
                    rom_cmd   = 1'b1;
                    ram_cmd_n = bank_sel_n;
                end
                PH_X2: begin
                    if (act.src) begin
                        data_en   = 1'b1;
                        data_o    = act.src_data[7:4];
                        rom_cmd   = 1'b1;
                        ram_cmd_n = bank_sel_n;
                    end
                end
                PH_X3: begin
                    if (act.src) begin
                        data_en = 1'b1;
                        data_o  = act.src_data[3:0];
                    end
                end
                default: begin
                    data_en = 1'b0;
                end
            endcase
        end
    end

endmodule
